wbram_stream_writer: RTL and testbench
======================================

Name: wbram_stream_writer

Overview:
- Upstream neighbour of the left-PE weight-BRAM read controller.
- Accepts weight words from an AXI-Stream source and writes them round-robin across NUM_BANKS weight-BRAM banks through port A, one layer per buffer.
- The BRAM is split into two halves, giving a double buffer with a 2-bit wrap-bit pointer.
- After each completed layer it publishes the write pointer to the reader over a valid/ready channel, and stalls when both buffers hold unread layers.

Parameters:
- STREAM_WIDTH, 128: AXI-Stream data width; equals BRAM write width.
- NUM_BANKS, 16: number of weight-BRAM banks.
- WBRAM_DEPTH, 112: words per bank; the two halves are buffers 0 and 1.
- BUF_DEPTH, WBRAM_DEPTH/2: words per bank per buffer.
- MAX_LAYER_BEATS, NUM_BANKS*BUF_DEPTH: maximum beats per layer.
- BW, $clog2(MAX_LAYER_BEATS+1): width of the beat-count config.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cfg_beats  in  BW  beats in next layer (1..MAX_LAYER_BEATS)
- cfg_valid  in  1  config valid
- cfg_ready  out  1  config ready
- s_tdata  in  STREAM_WIDTH  weight word
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- s_tlast  in  1  last beat of layer
- addrA  out  $clog2(WBRAM_DEPTH)  BRAM port-A address (common to all banks)
- diA  out  STREAM_WIDTH  BRAM write data
- enaA  out  NUM_BANKS  one-hot bank enable
- weA  out  NUM_BANKS  one-hot bank write enable
- wr_pointer_data  out  2  published write pointer
- wr_pointer_valid  out  1  pointer valid
- wr_pointer_ready  in  1  pointer ready (reader)
- rd_pointer_data  in  2  reader's read pointer
- rd_pointer_valid  in  1  read-pointer update pulse
- err_tlast  out  1  sticky framing error

Behaviour:
- Reset is asynchronous and active-low on rst_n; there is one clock, clk.
- Reset values: all outputs 0, except cfg_ready=1. The internal wr_ptr and rd_ptr_local reset to 0 and the FSM resets to IDLE.
- Reset asserted mid-layer discards the partial layer. No pointer is published for it.
- Buffer select is wr_ptr[0]. Buffer base address = wr_ptr[0] ? BUF_DEPTH : 0.
- full = (wr_ptr[0]==rd_ptr_local[0]) && (wr_ptr[1]!=rd_ptr_local[1]).
- rd_ptr_local loads rd_pointer_data on any cycle rd_pointer_valid=1. It is always accepted.
- FSM states: IDLE, WAIT_SPACE, WRITE, PUBLISH.
  - IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch cfg_beats, clear beat/bank/word counters, go to WAIT_SPACE.
  - WAIT_SPACE: go to WRITE when !full. full is evaluated with the rd_ptr_local value updated in the same cycle, so a simultaneous release gives a 1-cycle entry.
  - WRITE: s_tready=1. On s_tvalid&s_tready: register diA=s_tdata, addrA=base+word_cnt, enaA=weA=one-hot(bank_cnt) for exactly one cycle (write latency 1). bank_cnt then increments; at NUM_BANKS-1 it wraps to 0 and word_cnt increments. beat_cnt increments.
  - WRITE exit: on the beat where beat_cnt==cfg_beats-1, go to PUBLISH.
  - PUBLISH: s_tready=0. wr_pointer_valid=1 with wr_pointer_data=wr_ptr+1 (mod 4). Hold until wr_pointer_ready. On handshake, wr_ptr<=wr_ptr+1 and go to IDLE.
- Pointer publication is never earlier than the cycle after the last BRAM write strobe.
- s_tready is 0 in every state except WRITE. cfg_ready is 0 in every state except IDLE.
- Framing check:
  - s_tlast=1 on an accepted beat other than the final one sets err_tlast.
  - s_tlast=0 on the final beat also sets err_tlast.
  - Either way the layer still completes on the count.
  - err_tlast clears only on reset.
- Pointer wrap: 3→0 is mod-4 arithmetic.
- enaA/weA outside write strobes = 0. addrA and diA hold their last value.

Decomposition:
- Shared package wbram_pkg holds:
  - the FSM state enum wr_state_t;
  - localparams BUF_DEPTH and MAX_LAYER_BEATS;
  - function ptr_full(wr, rd), reused by the read controller's full/empty logic.
- The address generator (bank_cnt/word_cnt/base) is a natural sub-module, wbram_addr_gen, with ports clear, step, buf_sel, addr, bank_onehot.

Test Plan:
- Reset, cfg_beats=32, 32 back-to-back beats with tlast on beat 31:
  - Expected: banks 0..15 written at addr 0 then addr 1; wr_pointer_data=1 with valid asserted the cycle after the last strobe; err_tlast=0.
- Two layers of 16 beats with no rd_pointer update:
  - Expected: layer 1 lands at addr 56; the third cfg is accepted but the block holds in WAIT_SPACE with s_tready=0.
  - Then a rd_pointer_valid pulse with data 1: writing resumes at addr 0 in the next cycle.
- Hold wr_pointer_ready=0 for 5 cycles in PUBLISH:
  - Expected: valid and data stable, s_tready=0; advance only on ready.
- cfg_beats=20 with tlast on beat 10:
  - Expected: err_tlast=1 from the next cycle; all 20 beats are still written and the pointer is published.
- Four 1-beat layers, with the reader acknowledging each:
  - Expected: published pointers 1,2,3,0; bank 0 written at addrs 0,56,0,56.
- Assert rst_n low mid-layer at beat 7:
  - Expected: all outputs reset immediately (async); no pointer valid; next layer starts at addr 0 of buffer 0.

Source files
------------

// File: rtl/wbram_pkg.sv
// ---------------------------------------------------------------------------
// wbram_pkg
// Shared definitions for the weight-BRAM writer and its read-side partner:
//   - wr_state_t      : writer FSM state encoding
//   - BUF_DEPTH       : words per bank per buffer (default geometry)
//   - MAX_LAYER_BEATS : maximum beats per layer (default geometry)
//   - ptr_full()      : double-buffer full test on 2-bit wrap-bit pointers
// ---------------------------------------------------------------------------
package wbram_pkg;

  localparam int DEF_NUM_BANKS   = 16;
  localparam int DEF_WBRAM_DEPTH = 112;
  localparam int BUF_DEPTH       = DEF_WBRAM_DEPTH / 2;
  localparam int MAX_LAYER_BEATS = DEF_NUM_BANKS * BUF_DEPTH;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    WRITE      = 2'd2,
    PUBLISH    = 2'd3
  } wr_state_t;

  // Same buffer index but opposite wrap bit: both buffers hold unread layers.
  function automatic logic ptr_full(input logic [1:0] wr, input logic [1:0] rd);
    return (wr[0] == rd[0]) && (wr[1] != rd[1]);
  endfunction

endpackage

// File: rtl/wbram_addr_gen.sv
// ---------------------------------------------------------------------------
// wbram_addr_gen
// Round-robin bank / word address generator for one layer.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   clear        : restart at bank 0, word 0 (start of a layer)
//   step         : one beat accepted; advance to the next bank
//   buf_sel      : buffer half being written (0 -> base 0, 1 -> base depth/2)
//   addr         : port-A address for the current beat
//   bank_onehot  : one-hot bank select for the current beat
// ---------------------------------------------------------------------------
module wbram_addr_gen
  import wbram_pkg::*;
#(
  parameter  int NUM_BANKS   = 16,
  parameter  int WBRAM_DEPTH = 112,
  localparam int AW          = $clog2(WBRAM_DEPTH),
  localparam int BKW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 buf_sel,
  output logic [AW-1:0]        addr,
  output logic [NUM_BANKS-1:0] bank_onehot
);

  logic [BKW-1:0] bank_cnt_r;
  logic [AW-1:0]  word_cnt_r;

  // Bank counter walks all banks before the word counter advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_cnt_r <= {BKW{1'b0}};
      word_cnt_r <= {AW{1'b0}};
    end else if (clear) begin
      bank_cnt_r <= {BKW{1'b0}};
      word_cnt_r <= {AW{1'b0}};
    end else if (step) begin
      if (bank_cnt_r == BKW'(NUM_BANKS - 1)) begin
        bank_cnt_r <= {BKW{1'b0}};
        word_cnt_r <= word_cnt_r + AW'(1);
      end else begin
        bank_cnt_r <= bank_cnt_r + BKW'(1);
      end
    end
  end

  // Buffer base plus word offset; bank decode to one-hot.
  always_comb begin
    addr        = (buf_sel ? AW'(WBRAM_DEPTH / 2) : {AW{1'b0}}) + word_cnt_r;
    bank_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_cnt_r;
  end

endmodule

// File: rtl/wbram_stream_writer.sv
// ---------------------------------------------------------------------------
// wbram_stream_writer
// Writes AXI-Stream weight words round-robin across NUM_BANKS weight-BRAM
// banks (port A), one layer per buffer half, and publishes the write pointer
// to the read controller after each completed layer.
// Ports:
//   cfg_beats/cfg_valid/cfg_ready          : per-layer beat count
//   s_tdata/s_tvalid/s_tready/s_tlast      : weight stream
//   addrA/diA/enaA/weA                     : BRAM port A (write latency 1)
//   wr_pointer_data/valid/ready            : published write pointer
//   rd_pointer_data/valid                  : reader's read pointer updates
//   err_tlast                              : sticky tlast framing error
// ---------------------------------------------------------------------------
module wbram_stream_writer
  import wbram_pkg::*;
#(
  parameter  int STREAM_WIDTH = 128,
  parameter  int NUM_BANKS    = 16,
  parameter  int WBRAM_DEPTH  = 112,
  parameter  int BW           = $clog2(NUM_BANKS * (WBRAM_DEPTH / 2) + 1),
  localparam int AW           = $clog2(WBRAM_DEPTH)
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BW-1:0]           cfg_beats,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [STREAM_WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [AW-1:0]           addrA,
  output logic [STREAM_WIDTH-1:0] diA,
  output logic [NUM_BANKS-1:0]    enaA,
  output logic [NUM_BANKS-1:0]    weA,
  output logic [1:0]              wr_pointer_data,
  output logic                    wr_pointer_valid,
  input  logic                    wr_pointer_ready,
  input  logic [1:0]              rd_pointer_data,
  input  logic                    rd_pointer_valid,
  output logic                    err_tlast
);

  wr_state_t             state_r, state_n;
  logic [1:0]            wr_ptr_r, rd_ptr_local_r;
  logic [BW-1:0]         cfg_beats_r, beat_cnt_r;
  logic                  cfg_ready_r, s_tready_r, ptr_valid_r, err_tlast_r;
  logic [1:0]            ptr_data_r;
  logic [AW-1:0]         addr_r;
  logic [STREAM_WIDTH-1:0] di_r;
  logic [NUM_BANKS-1:0]  ena_r;

  logic                  cfg_take_s, accept_s, last_s, full_s, pub_hs_s;
  logic [1:0]            rd_eff_s;
  logic [AW-1:0]         wr_addr_s;
  logic [NUM_BANKS-1:0]  bank_onehot_s;

  wbram_addr_gen #(
    .NUM_BANKS   (NUM_BANKS),
    .WBRAM_DEPTH (WBRAM_DEPTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cfg_take_s),
    .step        (accept_s),
    .buf_sel     (wr_ptr_r[0]),
    .addr        (wr_addr_s),
    .bank_onehot (bank_onehot_s)
  );

  // Handshake decodes; full uses this cycle's read-pointer update so a
  // release arriving while waiting lets the write start on the next cycle.
  always_comb begin
    cfg_take_s = (state_r == IDLE) && cfg_valid && cfg_ready_r;
    accept_s   = (state_r == WRITE) && s_tvalid && s_tready_r;
    last_s     = (beat_cnt_r == (cfg_beats_r - BW'(1)));
    pub_hs_s   = (state_r == PUBLISH) && ptr_valid_r && wr_pointer_ready;
    rd_eff_s   = rd_pointer_valid ? rd_pointer_data : rd_ptr_local_r;
    full_s     = ptr_full(wr_ptr_r, rd_eff_s);
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_take_s) state_n = WAIT_SPACE;
        else            state_n = IDLE;
      end
      WAIT_SPACE: begin
        if (!full_s) state_n = WRITE;
        else         state_n = WAIT_SPACE;
      end
      WRITE: begin
        if (accept_s && last_s) state_n = PUBLISH;
        else                    state_n = WRITE;
      end
      PUBLISH: begin
        if (pub_hs_s) state_n = IDLE;
        else          state_n = PUBLISH;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, ready flags (registered from next state), pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cfg_ready_r    <= 1'b1;
      s_tready_r     <= 1'b0;
      wr_ptr_r       <= 2'd0;
      rd_ptr_local_r <= 2'd0;
      cfg_beats_r    <= {BW{1'b0}};
      beat_cnt_r     <= {BW{1'b0}};
      err_tlast_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      cfg_ready_r <= (state_n == IDLE);
      s_tready_r  <= (state_n == WRITE);
      if (rd_pointer_valid) rd_ptr_local_r <= rd_pointer_data;
      if (pub_hs_s) wr_ptr_r <= wr_ptr_r + 2'd1;
      if (cfg_take_s) begin
        cfg_beats_r <= cfg_beats;
        beat_cnt_r  <= {BW{1'b0}};
      end else if (accept_s) begin
        beat_cnt_r  <= beat_cnt_r + BW'(1);
      end
      // tlast must coincide exactly with the counted final beat.
      if (accept_s && (s_tlast != last_s)) err_tlast_r <= 1'b1;
    end
  end

  // BRAM port-A strobe: one cycle per accepted beat; address/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {AW{1'b0}};
      di_r   <= {STREAM_WIDTH{1'b0}};
      ena_r  <= {NUM_BANKS{1'b0}};
    end else if (accept_s) begin
      addr_r <= wr_addr_s;
      di_r   <= s_tdata;
      ena_r  <= bank_onehot_s;
    end else begin
      ena_r  <= {NUM_BANKS{1'b0}};
    end
  end

  // Pointer publication: valid rises one cycle after entering PUBLISH, i.e.
  // the cycle after the last write strobe is visible on port A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_valid_r <= 1'b0;
      ptr_data_r  <= 2'd0;
    end else if (pub_hs_s) begin
      ptr_valid_r <= 1'b0;
    end else if ((state_r == PUBLISH) && !ptr_valid_r) begin
      ptr_valid_r <= 1'b1;
      ptr_data_r  <= wr_ptr_r + 2'd1;
    end
  end

  assign cfg_ready        = cfg_ready_r;
  assign s_tready         = s_tready_r;
  assign addrA            = addr_r;
  assign diA              = di_r;
  assign enaA             = ena_r;
  assign weA              = ena_r;
  assign wr_pointer_data  = ptr_data_r;
  assign wr_pointer_valid = ptr_valid_r;
  assign err_tlast        = err_tlast_r;

endmodule

// File: tb/tb_wbram_stream_writer.sv
module tb_wbram_stream_writer;

  localparam int SW = 128;
  localparam int NB = 16;
  localparam int BW = 10;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] cfg_beats = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [SW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [AW-1:0] addrA;
  logic [SW-1:0] diA;
  logic [NB-1:0] enaA, weA;
  logic [1:0]    wr_pointer_data;
  logic          wr_pointer_valid;
  logic          wr_pointer_ready = 1'b0;
  logic [1:0]    rd_pointer_data = 2'd0;
  logic          rd_pointer_valid = 1'b0;
  logic          err_tlast;

  int errors = 0;
  int checks = 0;

  wbram_stream_writer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_beats(cfg_beats), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .addrA(addrA), .diA(diA), .enaA(enaA), .weA(weA),
    .wr_pointer_data(wr_pointer_data), .wr_pointer_valid(wr_pointer_valid),
    .wr_pointer_ready(wr_pointer_ready),
    .rd_pointer_data(rd_pointer_data), .rd_pointer_valid(rd_pointer_valid),
    .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] pat(input int layer, input int i);
    logic [31:0] w;
    w = 32'hC0DE0000 ^ (32'(layer) << 12) ^ 32'(i);
    return {w, ~w, w ^ 32'h5A5A5A5A, 32'(i)};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    wr_pointer_ready = 1'b0; rd_pointer_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_cfg(input int beats);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_timeout: got %b expected 1", cfg_ready); end
    cfg_beats = BW'(beats); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_drop: got %b expected 0", cfg_ready); end
  endtask

  // Sends beats 0..nsend-1 of a layer of 'total' beats and checks each strobe.
  task automatic stream(input int layer, input int nsend, input int total,
                        input int tlast_at, input int base, input logic err_in);
    int n = 0;
    logic exp_err;
    logic [NB-1:0] exp_en;
    exp_err = err_in;
    while (s_tready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++; $display("FAIL tready_timeout: got %b expected 1", s_tready);
      return;
    end
    for (int i = 0; i < nsend; i++) begin
      s_tvalid = 1'b1; s_tdata = pat(layer, i); s_tlast = (i == tlast_at);
      tick();
      if ((i == tlast_at) != (i == total - 1)) exp_err = 1'b1;
      exp_en = NB'(1) << (i % NB);
      checks++;
      if (enaA !== exp_en || weA !== exp_en) begin errors++;
        $display("FAIL strobe_bank L%0d beat %0d: got ena=%h we=%h expected %h", layer, i, enaA, weA, exp_en); end
      checks++;
      if (addrA !== AW'(base + i / NB)) begin errors++;
        $display("FAIL strobe_addr L%0d beat %0d: got %0d expected %0d", layer, i, addrA, base + i / NB); end
      checks++;
      if (diA !== pat(layer, i)) begin errors++;
        $display("FAIL strobe_data L%0d beat %0d: got %h expected %h", layer, i, diA, pat(layer, i)); end
      checks++;
      if (err_tlast !== exp_err) begin errors++;
        $display("FAIL err_tlast L%0d beat %0d: got %b expected %b", layer, i, err_tlast, exp_err); end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // Called in the cycle the last strobe is visible.
  task automatic publish(input logic [1:0] exp_ptr, input int hold);
    checks++;
    if (wr_pointer_valid !== 1'b0 || s_tready !== 1'b0) begin errors++;
      $display("FAIL pub_early: got valid=%b tready=%b expected 0 0", wr_pointer_valid, s_tready); end
    tick();
    checks++;
    if (wr_pointer_valid !== 1'b1 || wr_pointer_data !== exp_ptr || enaA !== '0) begin errors++;
      $display("FAIL pub_valid: got valid=%b data=%0d ena=%h expected 1 %0d 0", wr_pointer_valid, wr_pointer_data, enaA, exp_ptr); end
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (wr_pointer_valid !== 1'b1 || wr_pointer_data !== exp_ptr || s_tready !== 1'b0 || cfg_ready !== 1'b0) begin errors++;
        $display("FAIL pub_hold cyc %0d: got valid=%b data=%0d tready=%b cfg_ready=%b expected 1 %0d 0 0",
                 h, wr_pointer_valid, wr_pointer_data, s_tready, cfg_ready, exp_ptr); end
    end
    wr_pointer_ready = 1'b1;
    tick();
    wr_pointer_ready = 1'b0;
    checks++;
    if (wr_pointer_valid !== 1'b0 || cfg_ready !== 1'b1) begin errors++;
      $display("FAIL pub_done: got valid=%b cfg_ready=%b expected 0 1", wr_pointer_valid, cfg_ready); end
  endtask

  task automatic rd_update(input logic [1:0] v);
    rd_pointer_data = v; rd_pointer_valid = 1'b1;
    tick();
    rd_pointer_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (cfg_ready !== 1'b1 || s_tready !== 1'b0 || enaA !== '0 || weA !== '0 || addrA !== '0 ||
        diA !== '0 || wr_pointer_valid !== 1'b0 || wr_pointer_data !== 2'd0 || err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got cfg_ready=%b tready=%b ena=%h we=%h addr=%0d valid=%b ptr=%0d err=%b",
               cfg_ready, s_tready, enaA, weA, addrA, wr_pointer_valid, wr_pointer_data, err_tlast);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_layer();
    do_cfg(32);
    stream(0, 32, 32, 31, 0, 1'b0);
    publish(2'd1, 0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_cfg(16); stream(1, 16, 16, 15, 0, 1'b0);  publish(2'd1, 0);
    do_cfg(16); stream(2, 16, 16, 15, 56, 1'b0); publish(2'd2, 0);
    do_cfg(16);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (s_tready !== 1'b0 || cfg_ready !== 1'b0) begin errors++;
        $display("FAIL full_stall cyc %0d: got tready=%b cfg_ready=%b expected 0 0", c, s_tready, cfg_ready); end
    end
    rd_update(2'd1);
    checks++;
    if (s_tready !== 1'b1) begin errors++;
      $display("FAIL release_entry: got tready=%b expected 1", s_tready); end
    stream(3, 16, 16, 15, 0, 1'b0);
    publish(2'd3, 0);
  endtask

  task automatic test_publish_hold();
    rd_update(2'd3);
    do_cfg(8);
    stream(4, 8, 8, 7, 56, 1'b0);
    publish(2'd0, 5);
  endtask

  task automatic test_framing();
    apply_reset();
    do_cfg(20);
    stream(5, 20, 20, 10, 0, 1'b0);
    publish(2'd1, 0);
    checks++;
    if (err_tlast !== 1'b1) begin errors++;
      $display("FAIL err_sticky: got %b expected 1", err_tlast); end
  endtask

  task automatic test_ptr_wrap();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      do_cfg(1);
      stream(6 + k, 1, 1, 0, (k % 2 == 1) ? 56 : 0, 1'b0);
      publish(2'((k + 1) % 4), 0);
      rd_update(2'((k + 1) % 4));
    end
  endtask

  task automatic test_mid_reset();
    do_cfg(16);
    stream(10, 8, 16, 15, 0, 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (enaA !== '0 || weA !== '0 || addrA !== '0 || diA !== '0 || s_tready !== 1'b0 ||
        cfg_ready !== 1'b1 || wr_pointer_valid !== 1'b0 || err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ena=%h addr=%0d tready=%b cfg_ready=%b valid=%b expected 0 0 0 1 0",
               enaA, addrA, s_tready, cfg_ready, wr_pointer_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (wr_pointer_valid !== 1'b0) begin errors++;
        $display("FAIL no_pub_after_reset cyc %0d: got %b expected 0", c, wr_pointer_valid); end
    end
    do_cfg(16);
    stream(11, 16, 16, 15, 0, 1'b0);
    publish(2'd1, 0);
  endtask

  initial begin
    test_reset();
    test_basic_layer();
    test_back_to_back();
    test_publish_hold();
    test_framing();
    test_ptr_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
